// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, counter types and the flag bundle
// carried down the scan-out alignment pipeline.
// Optional feature macro: SCANOUT_BORDER_EN (adds a ring flag to the bundle).
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks from the start of the line.
    localparam int H_ACTIVE   = 640;
    localparam int H_FP_END   = 656;
    localparam int H_SYNC_END = 752;
    localparam int H_TOTAL    = 800;

    // Vertical timing, in lines from the start of the frame.
    localparam int V_ACTIVE   = 480;
    localparam int V_FP_END   = 490;
    localparam int V_SYNC_END = 492;
    localparam int V_TOTAL    = 525;

    typedef logic [9:0] hcount_t;
    typedef logic [9:0] vcount_t;

    // Per-position flags that must travel alongside the VRAM read so they
    // reach the output stage in the same clock as the pixel data.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
        logic win;
`ifdef SCANOUT_BORDER_EN
        logic ring;
`endif
        logic frame_start;
    } scan_flags_t;

    // What the pipeline holds while flushed: syncs idle high, everything else off.
    localparam scan_flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

    // Inclusive range test on a 10-bit raster coordinate.
    function automatic logic in_span(input logic [9:0] x,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running 800x525 raster counters with raw (unaligned) hsync, vsync,
// active-area and frame-start decodes for the counter position.
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    output hcount_t h,
    output vcount_t v,
    output logic    hsync,
    output logic    vsync,
    output logic    active,
    output logic    frame_start
);

    localparam hcount_t H_LAST       = hcount_t'(H_TOTAL - 1);
    localparam vcount_t V_LAST       = vcount_t'(V_TOTAL - 1);
    localparam hcount_t H_SYNC_FIRST = hcount_t'(H_FP_END);
    localparam hcount_t H_SYNC_LAST  = hcount_t'(H_SYNC_END - 1);
    localparam vcount_t V_SYNC_FIRST = vcount_t'(V_FP_END);
    localparam vcount_t V_SYNC_LAST  = vcount_t'(V_SYNC_END - 1);
    localparam hcount_t H_ACT_LIM    = hcount_t'(H_ACTIVE);
    localparam vcount_t V_ACT_LIM    = vcount_t'(V_ACTIVE);

    // Raster counters: h wraps at end of line, then v advances and wraps at end of frame.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Raw timing decodes for the position the counters currently hold.
    always_comb begin
        hsync       = !in_span(h, H_SYNC_FIRST, H_SYNC_LAST);
        vsync       = !in_span(v, V_SYNC_FIRST, V_SYNC_LAST);
        active      = (h < H_ACT_LIM) && (v < V_ACT_LIM);
        frame_start = (h == '0) && (v == '0);
    end

endmodule

// File: rtl/vram_scanout.sv
// GPU-side VRAM scan-out: generates 640x480@60 timing, reads the image out of
// VRAM in raster order and places it at (IMG_X0, IMG_Y0) on a black screen.
// Every output for raster position (h,v) appears VRAM_LATENCY+2 clocks after
// the counters hold (h,v): one clock to register gpu_address, VRAM_LATENCY
// for the read, one for the output register.
// Optional feature macro: SCANOUT_BORDER_EN draws a white 1-pixel ring around
// the image (inside the active area), regardless of display_en.
module vram_scanout
    import vga_timing_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int IMG_W        = 300,
    parameter int IMG_H        = 300,
    parameter int IMG_X0       = 170,
    parameter int IMG_Y0       = 90,
    parameter int VRAM_LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              display_en,
    output logic [ADDR_W-1:0] gpu_address,
    input  logic [7:0]        vram_out,
    output logic [7:0]        rgb_out,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start
);

    // Flag stages between the counters and the output register: one for the
    // address register plus one per VRAM latency clock.
    localparam int DEPTH = VRAM_LATENCY + 1;

    localparam hcount_t WX_FIRST = hcount_t'(IMG_X0);
    localparam hcount_t WX_LAST  = hcount_t'(IMG_X0 + IMG_W - 1);
    localparam vcount_t WY_FIRST = vcount_t'(IMG_Y0);
    localparam vcount_t WY_LAST  = vcount_t'(IMG_Y0 + IMG_H - 1);

`ifdef SCANOUT_BORDER_EN
    // Bounding box of window plus ring, clipped to the active area.
    localparam hcount_t BX_FIRST = hcount_t'((IMG_X0 > 0) ? IMG_X0 - 1 : 0);
    localparam hcount_t BX_LAST  = hcount_t'((IMG_X0 + IMG_W < H_ACTIVE) ? IMG_X0 + IMG_W : H_ACTIVE - 1);
    localparam vcount_t BY_FIRST = vcount_t'((IMG_Y0 > 0) ? IMG_Y0 - 1 : 0);
    localparam vcount_t BY_LAST  = vcount_t'((IMG_Y0 + IMG_H < V_ACTIVE) ? IMG_Y0 + IMG_H : V_ACTIVE - 1);
`endif

    // Elaboration-time geometry checks.
    if (IMG_W < 1 || IMG_H < 1 || IMG_X0 < 0 || IMG_Y0 < 0 ||
        IMG_X0 + IMG_W > H_ACTIVE || IMG_Y0 + IMG_H > V_ACTIVE) begin : g_bad_window
        $error("vram_scanout: image window does not fit inside the 640x480 active area");
    end
    if (VRAM_LATENCY < 1 || VRAM_LATENCY > 3) begin : g_bad_latency
        $error("vram_scanout: VRAM_LATENCY must be 1..3");
    end

    hcount_t           h;
    vcount_t           v;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              active_raw;
    logic              frame_start_raw;
    logic              in_win;
    scan_flags_t       stage0;
    scan_flags_t       pipe [DEPTH];
    scan_flags_t       aligned;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_base;
    logic [7:0]        pixel;

    vga_timing_gen u_timing (
        .clk         (clk),
        .reset       (reset),
        .h           (h),
        .v           (v),
        .hsync       (hsync_raw),
        .vsync       (vsync_raw),
        .active      (active_raw),
        .frame_start (frame_start_raw)
    );

    // Window (and ring) decode for the position the counters hold.
    always_comb begin
        in_win              = in_span(h, WX_FIRST, WX_LAST) && in_span(v, WY_FIRST, WY_LAST);
        stage0              = FLAGS_IDLE;
        stage0.hsync        = hsync_raw;
        stage0.vsync        = vsync_raw;
        stage0.blank_n      = active_raw;
        stage0.win          = in_win;
`ifdef SCANOUT_BORDER_EN
        stage0.ring         = in_span(h, BX_FIRST, BX_LAST) && in_span(v, BY_FIRST, BY_LAST) &&
                              active_raw && !in_win;
`endif
        stage0.frame_start  = frame_start_raw;
    end

    // addr_cnt is the index of the next window pixel; it restarts at the top of
    // every frame so a mid-frame reset or glitch never shifts the next image.
    assign addr_base = frame_start_raw ? '0 : addr_cnt;

    // Address register: issue the index of each in-window position, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt    <= '0;
            gpu_address <= '0;
        end else if (in_win) begin
            gpu_address <= addr_base;
            addr_cnt    <= addr_base + ADDR_W'(1);
        end else begin
            addr_cnt    <= addr_base;
        end
    end

    // Alignment pipeline: delays the timing flags by the address + VRAM latency.
    // NOTE: this small flag array is reset on purpose (unlike a data RAM) so a
    // reset flushes it and no stale sync pulse or frame_start leaks out after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= FLAGS_IDLE;
            end
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign aligned = pipe[DEPTH-1];

    // Pixel select: image data only inside the window while enabled.
    // NOTE: pixel gets its default first so no path through this block infers a latch.
    always_comb begin
        pixel = 8'h00;
        if (aligned.win && display_en) begin
            pixel = vram_out;
        end
`ifdef SCANOUT_BORDER_EN
        if (aligned.ring) begin
            pixel = 8'hFF;
        end
`endif
    end

    // Output register: every output leaves the block from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_out     <= 8'h00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb_out     <= pixel;
            hsync       <= aligned.hsync;
            vsync       <= aligned.vsync;
            blank_n     <= aligned.blank_n;
            frame_start <= aligned.frame_start;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout. The window is shrunk vertically (lines 3..14) so
// the whole image, both ring lines and a mid-frame reset fit in a short run.
// Expected outputs come from a position-based model: the output seen k clocks
// after reset release belongs to raster position k-PIPE.
module tb_vram_scanout;

    localparam int LAT   = 1;
    localparam int PIPE  = LAT + 2;
    localparam int IW    = 300;
    localparam int IH    = 12;
    localparam int IX0   = 170;
    localparam int IY0   = 3;
    localparam int HT    = 800;
    localparam int VT    = 525;
    localparam int FRAME = HT * VT;
`ifdef SCANOUT_BORDER_EN
    localparam logic [7:0] RING = 8'hFF;
`else
    localparam logic [7:0] RING = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        display_en = 1'b1;
    logic [31:0] gpu_address;
    logic [7:0]  vram_out;
    logic [7:0]  rgb_out;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        frame_start;
    logic [7:0]  vram_q [LAT];

    vram_scanout #(
        .ADDR_W       (32),
        .IMG_W        (IW),
        .IMG_H        (IH),
        .IMG_X0       (IX0),
        .IMG_Y0       (IY0),
        .VRAM_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .display_en  (display_en),
        .gpu_address (gpu_address),
        .vram_out    (vram_out),
        .rgb_out     (rgb_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // VRAM read port: data = address[7:0], valid LAT clocks after the address.
    always @(posedge clk) begin
        vram_q[0] <= gpu_address[7:0];
        for (int i = 1; i < LAT; i++) begin
            vram_q[i] <= vram_q[i-1];
        end
    end
    assign vram_out = vram_q[LAT-1];

    typedef struct {
        int         h;
        int         v;
        logic       de;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
    } vec_t;

    typedef struct {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
    } exp_t;

    int          k;
    int          vectors;
    int          miscompares;
    int          first_fall;
    int          first_fs;
    logic [31:0] exp_addr;

    function automatic bit is_win(int h, int v);
        return (h >= IX0) && (h < IX0 + IW) && (v >= IY0) && (v < IY0 + IH);
    endfunction

    function automatic int win_index(int h, int v);
        return (v - IY0) * IW + (h - IX0);
    endfunction

    function automatic bit is_ring(int h, int v);
        return !is_win(h, v) && (h >= IX0 - 1) && (h <= IX0 + IW) &&
               (v >= IY0 - 1) && (v <= IY0 + IH) && (h < 640) && (v < 480);
    endfunction

    // Expected outputs for raster position p (p < 0: pipeline still flushed).
    function automatic exp_t model_out(int p, logic de);
        exp_t e;
        int   pos;
        int   h;
        int   v;
        int   idx;
        e = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1, bn: 1'b0, fs: 1'b0};
        if (p < 0) return e;
        pos  = p % FRAME;
        h    = pos % HT;
        v    = pos / HT;
        e.hs = !((h >= 656) && (h < 752));
        e.vs = !((v >= 490) && (v < 492));
        e.bn = (h < 640) && (v < 480);
        e.fs = (pos == 0);
        if (is_ring(h, v)) begin
            e.rgb = RING;
        end else if (is_win(h, v) && de) begin
            idx   = win_index(h, v);
            e.rgb = idx[7:0];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at k=%0d: got %0h, want %0h", name, k, got, want);
        end
    endtask

    // One clock; track the address the counter position just issued, sample at negedge.
    task automatic step();
        int pos;
        @(posedge clk);
        k++;
        pos = (k - 1) % FRAME;
        if (is_win(pos % HT, pos / HT)) exp_addr = win_index(pos % HT, pos / HT);
        @(negedge clk);
        if (first_fall < 0 && hsync === 1'b0) first_fall = k;
        if (first_fs < 0 && frame_start === 1'b1) first_fs = k;
    endtask

    task automatic check_model();
        exp_t e;
        e = model_out(k - PIPE, display_en);
        check("rgb_out",     {24'h0, rgb_out}, {24'h0, e.rgb});
        check("hsync",       {31'h0, hsync}, {31'h0, e.hs});
        check("vsync",       {31'h0, vsync}, {31'h0, e.vs});
        check("blank_n",     {31'h0, blank_n}, {31'h0, e.bn});
        check("frame_start", {31'h0, frame_start}, {31'h0, e.fs});
        check("gpu_address", gpu_address, exp_addr);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gpu_address"}, gpu_address, 32'h0);
        check({tag, "_rgb_out"},     {24'h0, rgb_out}, 32'h0);
        check({tag, "_hsync"},       {31'h0, hsync}, 32'h1);
        check({tag, "_vsync"},       {31'h0, vsync}, 32'h1);
        check({tag, "_blank_n"},     {31'h0, blank_n}, 32'h0);
        check({tag, "_frame_start"}, {31'h0, frame_start}, 32'h0);
    endtask

    // Hold reset for 3 clocks from an arbitrary mid-cycle point, release at negedge.
    task automatic async_reset(input string tag);
        #7 reset = 1'b0;
        #1 check_reset_vals(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        k          = 0;
        exp_addr   = 32'h0;
        first_fs   = -1;
    endtask

    initial begin
        vec_t tbl [24];
        int   target;

        //            h    v   de    rgb    hs    vs    bn    fs
        tbl[0]  = '{  0,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{  1,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{639,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{640,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{655,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{656,   0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{751,   0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{752,   0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{170,   2, 1'b1, RING,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{168,   3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{169,   3, 1'b1, RING,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{170,   3, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{171,   3, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{172,   3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{173,   3, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{469,   3, 1'b1, 8'h2B, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{470,   3, 1'b1, RING,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{170,   4, 1'b1, 8'h2C, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{700,   5, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{470,   8, 1'b1, RING,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{471,   8, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[21] = '{469,  14, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{170,  15, 1'b1, RING,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[23] = '{170,  16, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

        k           = 0;
        vectors     = 0;
        miscompares = 0;
        first_fall  = -1;
        first_fs    = -1;
        exp_addr    = 32'h0;

        // Power-on reset values, then release at a negedge.
        @(negedge clk);
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // Table-driven spot checks along the first frame.
        for (int i = 0; i < 24; i++) begin
            target = tbl[i].v * HT + tbl[i].h + PIPE;
            while (k < target - 1) step();
            display_en = tbl[i].de;
            step();
            check($sformatf("rgb(%0d,%0d)", tbl[i].h, tbl[i].v),         {24'h0, rgb_out}, {24'h0, tbl[i].rgb});
            check($sformatf("hsync(%0d,%0d)", tbl[i].h, tbl[i].v),       {31'h0, hsync}, {31'h0, tbl[i].hs});
            check($sformatf("vsync(%0d,%0d)", tbl[i].h, tbl[i].v),       {31'h0, vsync}, {31'h0, tbl[i].vs});
            check($sformatf("blank_n(%0d,%0d)", tbl[i].h, tbl[i].v),     {31'h0, blank_n}, {31'h0, tbl[i].bn});
            check($sformatf("frame_start(%0d,%0d)", tbl[i].h, tbl[i].v), {31'h0, frame_start}, {31'h0, tbl[i].fs});
            display_en = 1'b1;
        end
        check("hsync_first_fall_clocks", first_fall, 656 + PIPE);
        check("addr_after_last_pixel", gpu_address, IW * IH - 1);

        // Random display_en against the model, then a reset while the counters
        // sit mid-line inside the window.
        async_reset("reset_a");
        while (k < 5 * HT + 300) begin
            step();
            check_model();
            display_en = ($urandom_range(0, 3) != 0);
        end
        async_reset("reset_mid");

        // Whole image with display disabled (addresses must still sweep), then random.
        display_en = 1'b0;
        while (k < 13000) begin
            step();
            check_model();
            if (k >= 12000) display_en = $urandom_range(0, 1);
        end
        check("frame_start_after_reset", first_fs, PIPE);
        check("addr_sweep_end", gpu_address, IW * IH - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
